// File: rtl/itcm_icb_sched_pkg.sv
// Shared sizing for the ITCM ICB scheduler: default ITCM geometry and small index helpers.
package itcm_icb_sched_pkg;

  localparam int ITCM_ADDR_WIDTH = 16;
  localparam int ITCM_DATA_WIDTH = 64;
  localparam int ITCM_WMSK_WIDTH = ITCM_DATA_WIDTH / 8;
  localparam int ITCM_RAM_AW     = ITCM_ADDR_WIDTH - $clog2(ITCM_WMSK_WIDTH);
  localparam int ITCM_OUTS_NUM   = 2;

  function automatic int rr_index(input int last, input int step, input int num);
    return (last + step) % num;
  endfunction

  function automatic int wrap_inc(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/itcm_rsp_fifo.sv
// Synchronous response FIFO; head entry is read straight from storage, pointers wrap modulo DEPTH.
module itcm_rsp_fifo
  import itcm_icb_sched_pkg::*;
#(
  parameter int W     = 66,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  output logic [W-1:0]     dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= PTR_W'(wrap_inc(int'(wptr), DEPTH));
      if (pop)  rptr <= PTR_W'(wrap_inc(int'(rptr), DEPTH));
      if (push && !pop)      cnt <= cnt + 1'b1;
      else if (pop && !push) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= din;
  end

  assign dout  = mem[rptr];
  assign empty = (cnt == '0);
  assign full  = (cnt == CNT_W'(DEPTH));
  assign count = cnt;

endmodule

// File: rtl/itcm_icb_sched.sv
// Round-robin ICB scheduler in front of the single-port ITCM SRAM with in-order response return.
module itcm_icb_sched
  import itcm_icb_sched_pkg::*;
#(
  parameter int ARBT_NUM   = ITCM_OUTS_NUM,
  parameter int ARBT_PTR_W = 1,
  parameter int AW         = ITCM_ADDR_WIDTH,
  parameter int DW         = ITCM_DATA_WIDTH,
  parameter int RAM_AW     = ITCM_RAM_AW,
  parameter int RAM_DEPTH  = 8192,
  parameter int RSP_DEPTH  = 2,
  localparam int MW = DW / 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ARBT_NUM-1:0]    i_bus_icb_cmd_valid,
  output logic [ARBT_NUM-1:0]    i_bus_icb_cmd_ready,
  input  logic [ARBT_NUM-1:0]    i_bus_icb_cmd_read,
  input  logic [ARBT_NUM*AW-1:0] i_bus_icb_cmd_addr,
  input  logic [ARBT_NUM*DW-1:0] i_bus_icb_cmd_wdata,
  input  logic [ARBT_NUM*MW-1:0] i_bus_icb_cmd_wmask,
  output logic [ARBT_NUM-1:0]    i_bus_icb_rsp_valid,
  input  logic [ARBT_NUM-1:0]    i_bus_icb_rsp_ready,
  output logic [ARBT_NUM-1:0]    i_bus_icb_rsp_err,
  output logic [ARBT_NUM*DW-1:0] i_bus_icb_rsp_rdata,
  output logic                   ram_cs,
  output logic                   ram_we,
  output logic [RAM_AW-1:0]      ram_addr,
  output logic [MW-1:0]          ram_wem,
  output logic [DW-1:0]          ram_din,
  input  logic [DW-1:0]          ram_dout,
  output logic                   itcm_active
);

  localparam int ADDR_LSB = $clog2(MW);
  localparam int FW       = ARBT_PTR_W + 1 + DW;
  localparam int CNT_W    = $clog2(RSP_DEPTH + 1);
  localparam logic [RAM_AW:0] DEPTH_LIM = (RAM_AW + 1)'(RAM_DEPTH);

  logic [ARBT_PTR_W-1:0] last_grant;
  logic [ARBT_PTR_W-1:0] gnt_id;
  logic [ARBT_PTR_W-1:0] cand;
  logic                  gnt_any;
  logic                  credit;
  logic                  issue;
  logic                  rsp_pop;
  logic                  sel_read;
  logic [AW-1:0]         sel_addr;
  logic [RAM_AW-1:0]     word_idx;
  logic                  in_range;
  logic                  unused_addr_lsb;

  logic                  inf_vld_p1;
  logic [ARBT_PTR_W-1:0] inf_id_p1;
  logic                  inf_err_p1;
  logic                  inf_read_p1;

  logic [DW-1:0]         push_rdata;
  logic [FW-1:0]         fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [ARBT_PTR_W-1:0] head_id;
  logic                  head_err;
  logic [DW-1:0]         head_rdata;

  // Stage p0: round-robin pick starting just after the last granted requester
  always_comb begin
    gnt_id  = last_grant;
    gnt_any = 1'b0;
    cand    = last_grant;
    for (int k = 1; k <= ARBT_NUM; k++) begin
      cand = ARBT_PTR_W'(rr_index(int'(last_grant), k, ARBT_NUM));
      if (!gnt_any && i_bus_icb_cmd_valid[cand]) begin
        gnt_any = 1'b1;
        gnt_id  = cand;
      end
    end
  end

  // A response leaving this cycle frees its slot for a same-cycle issue.
  assign credit  = ((int'(inf_vld_p1) + int'(fifo_count) - int'(rsp_pop)) < RSP_DEPTH)
                   && (!fifo_full || rsp_pop);
  assign issue   = gnt_any && credit && !rst;
  assign i_bus_icb_cmd_ready = issue ? (ARBT_NUM'(1) << gnt_id) : '0;

  assign sel_read = i_bus_icb_cmd_read[gnt_id];
  assign sel_addr = i_bus_icb_cmd_addr[gnt_id*AW +: AW];
  assign word_idx = sel_addr[AW-1:ADDR_LSB];
  assign in_range = ({1'b0, word_idx} < DEPTH_LIM);
  assign unused_addr_lsb = ^sel_addr[ADDR_LSB-1:0];

  assign ram_cs   = issue && in_range;
  assign ram_we   = ram_cs && !sel_read;
  assign ram_addr = word_idx;
  assign ram_wem  = ram_we ? i_bus_icb_cmd_wmask[gnt_id*MW +: MW] : '0;
  assign ram_din  = i_bus_icb_cmd_wdata[gnt_id*DW +: DW];

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= ARBT_PTR_W'(ARBT_NUM - 1);
      inf_vld_p1 <= 1'b0;
    end else begin
      if (issue) last_grant <= gnt_id;
      inf_vld_p1 <= issue;
    end
  end

  always_ff @(posedge clk) begin
    inf_id_p1   <= gnt_id;
    inf_err_p1  <= !in_range;
    inf_read_p1 <= sel_read;
  end

  // Stage p1: SRAM data is valid now; capture the response entry
  assign push_rdata = (inf_read_p1 && !inf_err_p1) ? ram_dout : '0;

  itcm_rsp_fifo #(
    .W     (FW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inf_vld_p1),
    .din   ({inf_id_p1, inf_err_p1, push_rdata}),
    .pop   (rsp_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Stage p2: FIFO head is routed only to its owner
  assign head_id    = fifo_dout[FW-1 -: ARBT_PTR_W];
  assign head_err   = fifo_dout[DW];
  assign head_rdata = fifo_dout[DW-1:0];
  assign rsp_pop    = !fifo_empty && i_bus_icb_rsp_ready[head_id];

  always_comb begin
    i_bus_icb_rsp_valid = '0;
    i_bus_icb_rsp_err   = '0;
    i_bus_icb_rsp_rdata = '0;
    for (int i = 0; i < ARBT_NUM; i++) begin
      if (!fifo_empty && (head_id == ARBT_PTR_W'(i))) begin
        i_bus_icb_rsp_valid[i]         = 1'b1;
        i_bus_icb_rsp_err[i]           = head_err;
        i_bus_icb_rsp_rdata[i*DW +: DW] = head_rdata;
      end
    end
  end

  assign itcm_active = !rst && ((|i_bus_icb_cmd_valid) || inf_vld_p1 || !fifo_empty);

endmodule

// File: tb/tb_itcm_icb_sched.sv
// Directed bench for itcm_icb_sched: driver pushes expected responses, a monitor pops and compares.
module tb_itcm_icb_sched;

  localparam int AN = 2;
  localparam int AW = 16;
  localparam int DW = 64;
  localparam int MW = 8;
  localparam int RAW = 13;

  logic clk = 1'b0;
  logic rst;
  logic [AN-1:0]    cmd_valid, cmd_ready, cmd_read;
  logic [AN*AW-1:0] cmd_addr;
  logic [AN*DW-1:0] cmd_wdata;
  logic [AN*MW-1:0] cmd_wmask;
  logic [AN-1:0]    rsp_valid, rsp_ready, rsp_err;
  logic [AN*DW-1:0] rsp_rdata;
  logic             ram_cs, ram_we, itcm_active;
  logic [RAW-1:0]   ram_addr;
  logic [MW-1:0]    ram_wem;
  logic [DW-1:0]    ram_din, ram_dout;

  typedef struct {
    int          id;
    bit          err;
    logic [63:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  logic [63:0] mem [0:4095];

  always #5 clk = ~clk;

  itcm_icb_sched #(
    .ARBT_NUM(AN), .ARBT_PTR_W(1), .AW(AW), .DW(DW),
    .RAM_AW(RAW), .RAM_DEPTH(4096), .RSP_DEPTH(2)
  ) dut (
    .clk(clk), .rst(rst),
    .i_bus_icb_cmd_valid(cmd_valid), .i_bus_icb_cmd_ready(cmd_ready),
    .i_bus_icb_cmd_read(cmd_read), .i_bus_icb_cmd_addr(cmd_addr),
    .i_bus_icb_cmd_wdata(cmd_wdata), .i_bus_icb_cmd_wmask(cmd_wmask),
    .i_bus_icb_rsp_valid(rsp_valid), .i_bus_icb_rsp_ready(rsp_ready),
    .i_bus_icb_rsp_err(rsp_err), .i_bus_icb_rsp_rdata(rsp_rdata),
    .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
    .ram_din(ram_din), .ram_dout(ram_dout), .itcm_active(itcm_active)
  );

  // Behavioural 1-cycle SRAM
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_addr >= 13'd4096) begin
        errors++;
        $display("FAIL sram_range actual=%0d required<4096", ram_addr);
      end else begin
        if (ram_we)
          for (int b = 0; b < MW; b++)
            if (ram_wem[b]) mem[ram_addr[11:0]][b*8 +: 8] <= ram_din[b*8 +: 8];
        ram_dout <= mem[ram_addr[11:0]];
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Monitor: compare every response handshake against the scoreboard head
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if ((rsp_valid & (rsp_valid - 2'd1)) != 2'b00) begin
        errors++;
        $display("FAIL rsp_onehot actual=%b required=onehot0", rsp_valid);
      end
      for (int i = 0; i < AN; i++) begin
        if (rsp_valid[i] && rsp_ready[i]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected actual=id%0d required=none", i);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("rsp_id", 64'(i), 64'(e.id));
            chk("rsp_err", {63'd0, rsp_err[i]}, {63'd0, e.err});
            chk("rsp_rdata", rsp_rdata[i*DW +: DW], e.rdata);
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the handshake.
  task automatic issue(input int id, input bit rd, input logic [15:0] addr,
                       input logic [63:0] wd, input logic [7:0] wm, input bit exp_cs,
                       input bit exp_err, input logic [63:0] exp_rd, input string nm);
    bit done = 0;
    cmd_read[id] = rd;
    cmd_addr[id*AW +: AW] = addr;
    cmd_wdata[id*DW +: DW] = wd;
    cmd_wmask[id*MW +: MW] = wm;
    cmd_valid[id] = 1'b1;
    for (int n = 0; n < 50 && !done; n++) begin
      #1;
      if (cmd_ready[id]) begin
        done = 1;
        chk({nm, "_cs"}, {63'd0, ram_cs}, {63'd0, exp_cs});
        if (exp_cs) begin
          chk({nm, "_addr"}, 64'(ram_addr), 64'(addr >> 3));
          chk({nm, "_we"}, {63'd0, ram_we}, {63'd0, !rd});
        end
        exp_q.push_back('{id, exp_err, exp_rd});
      end
      @(negedge clk);
    end
    cmd_valid[id] = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout actual=no_ready required=handshake", nm);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = '0;
    ram_dout  = '0;
    rst       = 1'b1;
    cmd_valid = 2'b11;
    cmd_read  = '0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_wmask = '0;
    rsp_ready = 2'b11;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_ram_cs", {63'd0, ram_cs}, 64'd0);
    chk("rst_active", {63'd0, itcm_active}, 64'd0);
    @(negedge clk);
    cmd_valid = 2'b00;
    rst = 1'b0;

    // 1. write then read back
    issue(0, 0, 16'h0010, 64'h1122334455667788, 8'hFF, 1, 0, 64'd0, "t1_wr");
    issue(0, 1, 16'h0010, 64'd0, 8'h00, 1, 0, 64'h1122334455667788, "t1_rd");
    drain();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // 2. both requesters contend for 4 cycles
    cmd_read = 2'b11;
    cmd_addr[0 +: AW] = 16'h0010;
    cmd_addr[AW +: AW] = 16'h0018;
    cmd_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("t2_grant", 64'(cmd_ready), (k % 2 == 0) ? 64'd1 : 64'd2);
      if (k % 2 == 0) exp_q.push_back('{0, 1'b0, 64'h1122334455667788});
      else            exp_q.push_back('{1, 1'b0, 64'd0});
      @(negedge clk);
    end
    cmd_valid = 2'b00;
    drain();

    // 3. response backpressure on LSU
    rsp_ready[0] = 1'b0;
    issue(0, 1, 16'h0010, 64'd0, 8'h00, 1, 0, 64'h1122334455667788, "t3_rd0");
    issue(0, 1, 16'h0018, 64'd0, 8'h00, 1, 0, 64'd0, "t3_rd1");
    cmd_addr[0 +: AW] = 16'h0010;
    cmd_read[0] = 1'b1;
    cmd_valid[0] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_stall_ready", {63'd0, cmd_ready[0]}, 64'd0);
      chk("t3_head_valid", 64'(rsp_valid), 64'd1);
      @(negedge clk);
    end
    rsp_ready[0] = 1'b1;
    issue(0, 1, 16'h0010, 64'd0, 8'h00, 1, 0, 64'h1122334455667788, "t3_rd2");
    drain();

    // 4. out-of-range EXT read, then normal LSU read
    issue(1, 1, 16'h8000, 64'd0, 8'h00, 0, 1, 64'd0, "t4_oor");
    issue(0, 1, 16'h0010, 64'd0, 8'h00, 1, 0, 64'h1122334455667788, "t4_rd");

    // 5. byte write followed immediately by read of the same word
    issue(0, 0, 16'h0020, 64'hFFFFFFFFFFABFFFF, 8'h04, 1, 0, 64'd0, "t5_wr");
    issue(0, 1, 16'h0020, 64'd0, 8'h00, 1, 0, 64'h0000000000AB0000, "t5_rd");
    drain();

    // 6. reset with responses pending
    rsp_ready[0] = 1'b0;
    issue(0, 1, 16'h0010, 64'd0, 8'h00, 1, 0, 64'h1122334455667788, "t6_rd0");
    issue(0, 1, 16'h0018, 64'd0, 8'h00, 1, 0, 64'd0, "t6_rd1");
    @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #1;
    chk("t6_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("t6_active", {63'd0, itcm_active}, 64'd0);
    rst = 1'b0;
    rsp_ready = 2'b11;
    @(negedge clk);
    cmd_read = 2'b11;
    cmd_addr[0 +: AW] = 16'h0020;
    cmd_addr[AW +: AW] = 16'h0010;
    cmd_valid = 2'b11;
    #1;
    chk("t6_tie_grant", 64'(cmd_ready), 64'd1);
    exp_q.push_back('{0, 1'b0, 64'h0000000000AB0000});
    @(negedge clk);
    cmd_valid[0] = 1'b0;
    #1;
    chk("t6_next_grant", 64'(cmd_ready), 64'd2);
    exp_q.push_back('{1, 1'b0, 64'h1122334455667788});
    @(negedge clk);
    cmd_valid = 2'b00;
    drain();
    repeat (2) @(negedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    #1;
    chk("final_idle", {63'd0, itcm_active}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
